// File: rtl/conv_3x3_pkg.sv
// conv_3x3 shared package: element sizes, FSM states, timing constants.
// CONV3X3_SATURATE_EN makes clip_out saturate instead of truncate.
package conv_pkg;

    localparam int DATA_W       = 8;
    localparam int ACC_W        = 20;
    localparam int K            = 3;
    localparam int MAP_N        = 4;
    localparam int N_WIN        = 4;
    localparam int CONV_LATENCY = 10;
    localparam int CNT_W        = 4;

    // Counter value at which window 0 leaves the bottom adder chain:
    // K rows of psum travel plus two column-alignment stages.
    localparam int CAP_FIRST = K + 2;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } state_t;

    function automatic logic [DATA_W-1:0] clip_out(
        input logic [ACC_W-1:0] s
    );
        logic [DATA_W-1:0] r;
        r = DATA_W'(s);
`ifdef CONV3X3_SATURATE_EN
        if (s > ACC_W'(2 ** DATA_W - 1))
            r = '1;
`endif
        return r;
    endfunction

endpackage

// File: rtl/conv_3x3_pe_mac.sv
// pe_mac: weight-stationary MAC cell of the conv_3x3 systolic array.
// Ports: w_load/w_in load the weight; act_in/act_out, psum_in/psum_out.
module pe_mac
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              w_load,
    input  logic [DATA_W-1:0] w_in,
    input  logic [DATA_W-1:0] act_in,
    input  logic [ACC_W-1:0]  psum_in,
    output logic [DATA_W-1:0] act_out,
    output logic [ACC_W-1:0]  psum_out
);

    logic [DATA_W-1:0]   weight_q;
    logic [2*DATA_W-1:0] prod;

    assign prod = {{DATA_W{1'b0}}, act_in}
                * {{DATA_W{1'b0}}, weight_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            weight_q <= '0;
            act_out  <= '0;
            psum_out <= '0;
        end else begin
            if (w_load)
                weight_q <= w_in;
            act_out  <= act_in;
            psum_out <= psum_in + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/conv_3x3.sv
// conv_3x3: 3x3 weight-stationary systolic convolution of a 4x4 map.
// Ports: start, weight_load, w_11..w_33, in_11..in_44 in; conv_out_*, done out.
// Build option CONV3X3_SATURATE_EN: saturate outputs instead of truncating.
module conv_3x3
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              weight_load,
    input  logic [DATA_W-1:0] w_11,
    input  logic [DATA_W-1:0] w_12,
    input  logic [DATA_W-1:0] w_13,
    input  logic [DATA_W-1:0] w_21,
    input  logic [DATA_W-1:0] w_22,
    input  logic [DATA_W-1:0] w_23,
    input  logic [DATA_W-1:0] w_31,
    input  logic [DATA_W-1:0] w_32,
    input  logic [DATA_W-1:0] w_33,
    input  logic [DATA_W-1:0] in_11,
    input  logic [DATA_W-1:0] in_12,
    input  logic [DATA_W-1:0] in_13,
    input  logic [DATA_W-1:0] in_14,
    input  logic [DATA_W-1:0] in_21,
    input  logic [DATA_W-1:0] in_22,
    input  logic [DATA_W-1:0] in_23,
    input  logic [DATA_W-1:0] in_24,
    input  logic [DATA_W-1:0] in_31,
    input  logic [DATA_W-1:0] in_32,
    input  logic [DATA_W-1:0] in_33,
    input  logic [DATA_W-1:0] in_34,
    input  logic [DATA_W-1:0] in_41,
    input  logic [DATA_W-1:0] in_42,
    input  logic [DATA_W-1:0] in_43,
    input  logic [DATA_W-1:0] in_44,
    output logic [DATA_W-1:0] conv_out_11,
    output logic [DATA_W-1:0] conv_out_12,
    output logic [DATA_W-1:0] conv_out_21,
    output logic [DATA_W-1:0] conv_out_22,
    output logic              done
);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              busy;
    logic              start_ok;
    logic              w_load;

    logic [DATA_W-1:0] w_bus  [K][K];
    logic [DATA_W-1:0] in_bus [MAP_N][MAP_N];
    logic [DATA_W-1:0] in_buf [MAP_N][MAP_N];
    logic [DATA_W-1:0] act_in [K][K];
    logic [ACC_W-1:0]  psum   [K][K];

    logic [K*K*DATA_W-1:0] act_tap_unused;

    logic [ACC_W-1:0]  align0;
    logic [ACC_W-1:0]  align1;
    logic [ACC_W-1:0]  total;
    logic              cap_en;
    logic [1:0]        cap_idx;
    logic [DATA_W-1:0] out_q [N_WIN];

    assign w_bus[0][0] = w_11;
    assign w_bus[0][1] = w_12;
    assign w_bus[0][2] = w_13;
    assign w_bus[1][0] = w_21;
    assign w_bus[1][1] = w_22;
    assign w_bus[1][2] = w_23;
    assign w_bus[2][0] = w_31;
    assign w_bus[2][1] = w_32;
    assign w_bus[2][2] = w_33;

    assign in_bus[0][0] = in_11;
    assign in_bus[0][1] = in_12;
    assign in_bus[0][2] = in_13;
    assign in_bus[0][3] = in_14;
    assign in_bus[1][0] = in_21;
    assign in_bus[1][1] = in_22;
    assign in_bus[1][2] = in_23;
    assign in_bus[1][3] = in_24;
    assign in_bus[2][0] = in_31;
    assign in_bus[2][1] = in_32;
    assign in_bus[2][2] = in_33;
    assign in_bus[2][3] = in_34;
    assign in_bus[3][0] = in_41;
    assign in_bus[3][1] = in_42;
    assign in_bus[3][2] = in_43;
    assign in_bus[3][3] = in_44;

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start) state_nxt = FEED;
            FEED:  if (cnt == CNT_W'(N_WIN - 1)) state_nxt = DRAIN;
            DRAIN: if (cnt == CNT_W'(CONV_LATENCY - 1)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        done     = 1'b0;
        busy     = 1'b0;
        start_ok = 1'b0;
        w_load   = 1'b0;
        unique case (state)
            IDLE: begin
                start_ok = start;
                w_load   = weight_load;
            end
            FEED:  busy = 1'b1;
            DRAIN: busy = 1'b1;
            DONE:  done = 1'b1;
            default: done = 1'b0;
        endcase
    end

    // Counts from the start edge; also pads DRAIN out to the fixed latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (busy)
            cnt <= cnt + 1'b1;
        else
            cnt <= '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < MAP_N; r++)
                for (int c = 0; c < MAP_N; c++)
                    in_buf[r][c] <= '0;
        end else if (start_ok) begin
            in_buf <= in_bus;
        end
    end

    // Skewed feed: PE(i,j) works on window (cnt - i - j), so a window's
    // psum meets row i exactly when its activation for that row arrives.
    // Window k covers rows k/2.., columns k%2.. (order 11, 12, 21, 22).
    always_comb begin
        int         win;
        logic [1:0] rsel;
        logic [1:0] csel;
        win  = 0;
        rsel = '0;
        csel = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                act_in[i][j] = '0;
                win  = int'(cnt) - i - j;
                rsel = 2'((win >> 1) + i);
                csel = 2'((win & 1) + j);
                if (busy && win >= 0 && win < N_WIN)
                    act_in[i][j] = in_buf[rsel][csel];
            end
        end
    end

    // Activation passthroughs are tapped only at the array edge; every
    // PE column takes its activation from the skewed feed instead.
    for (genvar gi = 0; gi < K; gi++) begin : g_row
        for (genvar gj = 0; gj < K; gj++) begin : g_col
            logic [ACC_W-1:0] psum_in;
            if (gi == 0) begin : g_first
                assign psum_in = '0;
            end else begin : g_next
                assign psum_in = psum[gi-1][gj];
            end
            pe_mac u_pe (
                .clk      (clk),
                .rst      (rst),
                .w_load   (w_load),
                .w_in     (w_bus[gi][gj]),
                .act_in   (act_in[gi][gj]),
                .psum_in  (psum_in),
                .act_out  (act_tap_unused[(gi*K+gj)*DATA_W +: DATA_W]),
                .psum_out (psum[gi][gj])
            );
        end
    end

    // Column j finishes a window j cycles after column 0; align0/align1
    // delay the earlier columns so all three meet in total.
    assign total   = align1 + psum[K-1][2];
    assign cap_en  = busy
                   && cnt >= CNT_W'(CAP_FIRST)
                   && cnt <  CNT_W'(CAP_FIRST + N_WIN);
    assign cap_idx = 2'(cnt - CNT_W'(CAP_FIRST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            align0 <= '0;
            align1 <= '0;
            for (int n = 0; n < N_WIN; n++)
                out_q[n] <= '0;
        end else begin
            align0 <= psum[K-1][0];
            align1 <= align0 + psum[K-1][1];
            if (cap_en)
                out_q[cap_idx] <= clip_out(total);
        end
    end

    assign conv_out_11 = out_q[0];
    assign conv_out_12 = out_q[1];
    assign conv_out_21 = out_q[2];
    assign conv_out_22 = out_q[3];

endmodule

// File: tb/tb_conv_3x3.sv
// tb_conv_3x3: directed self-checking bench for conv_3x3.
// Hand-computed vectors; latency, single done pulse, reset, overflow.
module tb_conv_3x3;
    import conv_pkg::*;

    localparam int NONE = -10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              weight_load = 1'b0;
    logic [DATA_W-1:0] w_v  [9];
    logic [DATA_W-1:0] in_v [16];
    logic [DATA_W-1:0] o11, o12, o21, o22;
    logic              done;

    int                checks = 0;
    int                errors = 0;
    int                lat;
    int                nd;
    logic [DATA_W-1:0] got [4];
    logic [DATA_W-1:0] ovf_exp;

    always #5 clk = ~clk;

    conv_3x3 dut (
        .clk(clk), .rst(rst), .start(start), .weight_load(weight_load),
        .w_11(w_v[0]), .w_12(w_v[1]), .w_13(w_v[2]),
        .w_21(w_v[3]), .w_22(w_v[4]), .w_23(w_v[5]),
        .w_31(w_v[6]), .w_32(w_v[7]), .w_33(w_v[8]),
        .in_11(in_v[0]),  .in_12(in_v[1]),  .in_13(in_v[2]),  .in_14(in_v[3]),
        .in_21(in_v[4]),  .in_22(in_v[5]),  .in_23(in_v[6]),  .in_24(in_v[7]),
        .in_31(in_v[8]),  .in_32(in_v[9]),  .in_33(in_v[10]), .in_34(in_v[11]),
        .in_41(in_v[12]), .in_42(in_v[13]), .in_43(in_v[14]), .in_44(in_v[15]),
        .conv_out_11(o11), .conv_out_12(o12),
        .conv_out_21(o21), .conv_out_22(o22),
        .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_in_seq();
        for (int i = 0; i < 16; i++) in_v[i] = DATA_W'(i + 1);
    endtask

    task automatic set_in_all(input logic [DATA_W-1:0] v);
        for (int i = 0; i < 16; i++) in_v[i] = v;
    endtask

    task automatic set_w_all(input logic [DATA_W-1:0] v);
        for (int i = 0; i < 9; i++) w_v[i] = v;
    endtask

    task automatic set_w_nom();
        for (int i = 0; i < 9; i++) w_v[i] = (i % 2 == 0) ? 8'd1 : 8'd0;
    endtask

    task automatic load_w();
        @(negedge clk);
        weight_load = 1'b1;
        @(posedge clk);
        #1 weight_load = 1'b0;
    endtask

    task automatic run_conv(input int poke_at, input int rst_at,
                            input bit wl_too, input bit stop_on_done);
        lat = 0;
        nd  = 0;
        for (int i = 0; i < 4; i++) got[i] = '0;
        @(negedge clk);
        start       = 1'b1;
        weight_load = wl_too;
        @(posedge clk);
        #1;
        start       = 1'b0;
        weight_load = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                nd++;
                if (lat == 0) begin
                    lat = c;
                    got[0] = o11; got[1] = o12;
                    got[2] = o21; got[3] = o22;
                end
            end
            if (stop_on_done && nd > 0) break;
            if (c == poke_at) begin
                start = 1'b1;
                weight_load = 1'b1;
                set_w_all(8'd0);
                set_in_all(8'd99);
            end
            if (c == poke_at + 1) begin
                start = 1'b0;
                weight_load = 1'b0;
            end
            if (c == rst_at) begin
                rst = 1'b0;
                #1;
                chk("midrst_o11", o11, 0);
                chk("midrst_o12", o12, 0);
                chk("midrst_o21", o21, 0);
                chk("midrst_o22", o22, 0);
                chk("midrst_done", done, 0);
            end
            if (c == rst_at + 2) rst = 1'b1;
        end
    endtask

    task automatic chk_run(input string tag, input int e0, input int e1,
                           input int e2, input int e3);
        chk({tag, "_lat"}, lat, 10);
        chk({tag, "_o11"}, got[0], e0);
        chk({tag, "_o12"}, got[1], e1);
        chk({tag, "_o21"}, got[2], e2);
        chk({tag, "_o22"}, got[3], e3);
    endtask

    initial begin
`ifdef CONV3X3_SATURATE_EN
        ovf_exp = 8'd255;
`else
        ovf_exp = 8'h09;
`endif
        set_w_all(8'd0);
        set_in_all(8'd0);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o11", o11, 0);
        chk("rst_o12", o12, 0);
        chk("rst_o21", o21, 0);
        chk("rst_o22", o22, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;

        // nominal
        set_w_nom();
        set_in_seq();
        load_w();
        run_conv(NONE, NONE, 1'b0, 1'b0);
        chk_run("nom", 30, 35, 50, 55);
        chk("nom_ndone", nd, 1);

        // busy-time start/weight_load/input changes ignored
        run_conv(3, NONE, 1'b0, 1'b0);
        chk_run("busy", 30, 35, 50, 55);
        chk("busy_ndone", nd, 1);
        set_in_seq();
        run_conv(NONE, NONE, 1'b0, 1'b0);
        chk_run("oldw", 30, 35, 50, 55);

        // identity centre
        set_w_all(8'd0);
        w_v[4] = 8'd1;
        load_w();
        run_conv(NONE, NONE, 1'b0, 1'b0);
        chk_run("ident", 6, 7, 10, 11);

        // weight_load together with start uses the bus weights
        set_w_nom();
        run_conv(NONE, NONE, 1'b1, 1'b0);
        chk_run("same_edge", 30, 35, 50, 55);

        // overflow
        set_w_all(8'd255);
        set_in_all(8'd255);
        load_w();
        run_conv(NONE, NONE, 1'b0, 1'b0);
        chk_run("ovf", ovf_exp, ovf_exp, ovf_exp, ovf_exp);

        // async reset mid-run
        run_conv(NONE, 4, 1'b0, 1'b0);
        chk("midrst_ndone", nd, 0);
        set_w_nom();
        set_in_seq();
        load_w();
        run_conv(NONE, NONE, 1'b0, 1'b0);
        chk_run("after_rst", 30, 35, 50, 55);

        // back-to-back
        run_conv(NONE, NONE, 1'b0, 1'b1);
        chk_run("b2b_a", 30, 35, 50, 55);
        @(posedge clk);
        #1;
        set_in_all(8'd2);
        run_conv(NONE, NONE, 1'b0, 1'b0);
        chk_run("b2b_b", 10, 10, 10, 10);
        chk("b2b_ndone", nd, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_3x3.md
Name: conv_3x3

Overview:
- Weight-stationary 3x3 systolic-array convolution engine.
- Convolves a 4x4 input map with a 3x3 kernel (stride 1, no padding), giving a 2x2 output map.
- Sits under the top-level controller, which pulses weight_load, then start, then waits for done and captures the four outputs.

Parameters:
- DATA_W, 8: width of every weight, input and output element (unsigned).
- ACC_W, 20: accumulator width; holds 9*255*255 = 585225 without overflow.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: begin convolution; sampled only in IDLE.
- weight_load, input, 1: latch w_11..w_33 into weight registers.
- w_11..w_33, input, DATA_W each: kernel element, row r column c (9 ports).
- in_11..in_44, input, DATA_W each: input map element, row r column c (16 ports).
- conv_out_11, conv_out_12, conv_out_21, conv_out_22, output, DATA_W each: output pixel (r,c), registered.
- done, output, 1: one-cycle pulse; outputs are valid in that cycle.

Behaviour:
- Reset (rst low, async): state IDLE, weight regs 0, input buffer 0, all PE accumulators 0, all conv_out 0, done 0.
- Math: conv_out_rc = sum over i,j in 0..2 of in_(r+i)(c+j) * w_(i+1)(j+1).
  - Products are 2*DATA_W bits; accumulate in ACC_W bits, unsigned.
  - Output is the low DATA_W bits of the sum (truncation) unless SATURATE_EN is defined.
- Weight load:
  - weight_load high in IDLE: weight regs <= w_* on that edge.
  - weight_load is ignored while busy.
- start in IDLE:
  - Latch all 16 in_* into the input buffer.
  - Go to FEED; windows are issued in order 11, 12, 21, 22.
  - If weight_load and start are high on the same edge, the computation uses the w_* bus values presented that cycle.
- States:
  - IDLE: wait for start.
  - FEED: 4 cycles. One window per cycle enters the array with row/column skew. PE(i,j) multiplies by its stationary weight and adds the incoming partial sum. Activations shift right; partial sums shift down.
  - DRAIN: cycles until the last window exits. Each result is written to its conv_out register as it exits.
  - DONE: assert done for exactly 1 cycle, return to IDLE.
- Latency is fixed: done is high exactly 10 clock edges after the edge that sampled start. Pad with the cycle counter if the array pipeline is shorter.
- All four conv_out values are final no later than the done cycle and hold until the next run's update.
- start while not in IDLE is ignored; there is no queueing.
- Input changes after start is sampled have no effect on the current run.
- Reset mid-operation aborts immediately to the reset values; done does not fire.
- Back-to-back: start may be sampled on the cycle after done (IDLE).

Optional Feature:
- Macro: CONV3X3_SATURATE_EN.
- Defined: each output = min(sum, 2^DATA_W - 1).
- Undefined: each output = sum[DATA_W-1:0].
- No other behavioural or timing difference.

Decomposition:
- Package conv_pkg holds:
  - DATA_W, ACC_W.
  - State enum: IDLE, FEED, DRAIN, DONE.
  - Latency constant CONV_LATENCY = 10.
  - Array dimension constant K = 3.
- Sub-module pe_mac is instantiated 9 times in a generate loop. It contains:
  - a stationary weight register;
  - a registered activation passthrough;
  - a registered psum_out = psum_in + act*weight;
  - async active-low reset.
- Top level holds the FSM, cycle counter, input buffer, skew/feed logic and output capture.

Test Plan:
- Nominal run:
  - Stimulus: reset; in = 1..16 row-major; w = [1 0 1; 0 1 0; 1 0 1]; weight_load pulse, then start.
  - Response: done exactly 10 cycles after start; outputs 11=30, 12=35, 21=50, 22=55.
- Identity-centre kernel:
  - Stimulus: w_22 = 1, all other weights 0, same inputs.
  - Response: outputs 6, 7, 10, 11.
- Overflow:
  - Stimulus: all in = 255, all w = 255 (sum 585225 = 0x8EE09).
  - Response without macro: every output = 0x09. With CONV3X3_SATURATE_EN: every output = 255.
- Ignored stimulus while busy:
  - Stimulus: start and weight_load re-pulsed mid-run with w = 0; in_* changed after start.
  - Response: exactly one done; outputs unchanged (30/35/50/55); later run uses the old weights.
- Async reset mid-run:
  - Stimulus: rst low at cycle 4 after start.
  - Response: outputs 0 and done 0 immediately; no done afterwards. A fresh start gives correct results.
- Back-to-back runs:
  - Stimulus: start on the cycle after done, with in = all 2 and unchanged weights.
  - Response: done after 10 cycles; all outputs = 10.
